// File: rtl/oppm_pulse_qualifier.sv
// Receive-side pulse qualifier: synchronises pulse_in, measures each high pulse and
// strobes accept/runt/long. Optional statistics counters under `define PULSE_STATS_EN.
module oppm_pulse_qualifier #(
    parameter int unsigned COUNT  = 8,
    parameter int unsigned TOL    = 1,
    parameter int unsigned GAP_CT = 4,
    parameter int unsigned WW     = $clog2(COUNT + TOL + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    output logic          pulse_ok,
    output logic [WW-1:0] width,
    output logic [WW+1:0] lead,
    output logic          err_runt,
    output logic          err_long,
    output logic          busy,
    input  logic          stats_clear,
    output logic [15:0]   cnt_ok,
    output logic [15:0]   cnt_err
);
    localparam int unsigned GW = (GAP_CT > 1) ? $clog2(GAP_CT) : 1;
    localparam logic [WW-1:0] WMin  = WW'(COUNT - TOL);
    localparam logic [WW-1:0] WMax  = WW'(COUNT + TOL);
    localparam logic [WW-1:0] WSat  = WW'(COUNT + TOL + 1);
    localparam logic [GW-1:0] GLast = GW'(GAP_CT - 1);

    if (GAP_CT == 0) begin : g_bad_gap
        $fatal(1, "oppm_pulse_qualifier: GAP_CT must be non-zero");
    end
    if (TOL >= COUNT) begin : g_bad_tol
        $fatal(1, "oppm_pulse_qualifier: TOL must be less than COUNT");
    end

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync_q, prev_q;
    logic [1:0]    fill_q;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          ok_q, ok_d, runt_q, runt_d, long_q, long_d;
    logic [WW-1:0] width_q, width_d;
    logic [WW+1:0] lead_q, lead_d;
    logic          rise;

    // prev_q holds 1 until the synchroniser carries real samples, so a pulse already
    // high when reset falls needs a genuine low sample before it can start a measurement.
    assign rise = fill_q[1] & sync_q & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            ok_q    <= 1'b0;
            runt_q  <= 1'b0;
            long_q  <= 1'b0;
            width_q <= '0;
            lead_q  <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= pulse_in;
            sync_q  <= sync1_q;
            prev_q  <= fill_q[1] ? sync_q : 1'b1;
            fill_q  <= {fill_q[0], 1'b1};
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            ok_q    <= ok_d;
            runt_q  <= runt_d;
            long_q  <= long_d;
            width_q <= width_d;
            lead_q  <= lead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        ok_d    = 1'b0;
        runt_d  = 1'b0;
        long_d  = 1'b0;
        width_d = width_q;
        lead_d  = lead_q;
        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    wcnt_d  = WW'(1);
                end
            end
            StHigh: begin
                if (sync_q) begin
                    if (wcnt_q != WSat) wcnt_d = wcnt_q + WW'(1);
                end else begin
                    state_d = StGap;
                    gcnt_d  = '0;
                    width_d = wcnt_q;
                    lead_d  = (WW+2)'(wcnt_q) + (WW+2)'(3);
                    if (wcnt_q < WMin)      runt_d = 1'b1;
                    else if (wcnt_q > WMax) long_d = 1'b1;
                    else                    ok_d   = 1'b1;
                end
            end
            StGap: begin
                if (gcnt_q == GLast) state_d = StIdle;
                else                 gcnt_d  = gcnt_q + GW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        pulse_ok = ok_q;
        err_runt = runt_q;
        err_long = long_q;
        width    = width_q;
        lead     = lead_q;
    end

`ifdef PULSE_STATS_EN
    logic [15:0] cnt_ok_q, cnt_err_q;

    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            if (ok_q && cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
            if ((runt_q || long_q) && cnt_err_q != 16'hFFFF) cnt_err_q <= cnt_err_q + 16'd1;
        end
    end

    assign cnt_ok  = cnt_ok_q;
    assign cnt_err = cnt_err_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = stats_clear;
    assign cnt_ok  = '0;
    assign cnt_err = '0;
`endif

endmodule

// File: tb/tb_oppm_pulse_qualifier.sv
// Directed bench for oppm_pulse_qualifier (COUNT=8, TOL=1, GAP_CT=4).
module tb_oppm_pulse_qualifier;
    localparam int unsigned WW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic          stats_clear = 1'b0;
    logic          pulse_ok, err_runt, err_long, busy;
    logic [WW-1:0] width;
    logic [WW+1:0] lead;
    logic [15:0]   cnt_ok, cnt_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Strobe / busy monitor, sampled on the falling edge
    int n_strobe = 0, last_cyc = -1, last_kind = 0, last_w = 0, last_l = 0, excl_bad = 0;
    int busy_rise = -1, busy_fall = -1;
    logic busy_prev = 1'b0;

    oppm_pulse_qualifier #(.COUNT(8), .TOL(1), .GAP_CT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .pulse_ok    (pulse_ok),
        .width       (width),
        .lead        (lead),
        .err_runt    (err_runt),
        .err_long    (err_long),
        .busy        (busy),
        .stats_clear (stats_clear),
        .cnt_ok      (cnt_ok),
        .cnt_err     (cnt_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pulse_ok || err_runt || err_long) begin
            n_strobe  = n_strobe + 1;
            last_cyc  = cyc;
            last_kind = {29'd0, pulse_ok, err_runt, err_long};
            last_w    = int'(width);
            last_l    = int'(lead);
        end
        if (int'(pulse_ok) + int'(err_runt) + int'(err_long) > 1) excl_bad = excl_bad + 1;
        if (busy && !busy_prev) busy_rise = cyc;
        if (busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive pulse_in high for w cycles starting in cycle t
    task automatic pulse(input int w, output int t);
        @(posedge clk);
        #1 pulse_in = 1'b1;
        t = cyc;
        repeat (w) @(posedge clk);
        #1 pulse_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t, t2, n0;
    int bw[4] = '{7, 9, 6, 10};
    int bk[4] = '{4, 4, 2, 1};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pulse_ok", int'(pulse_ok), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_width", int'(width), 0);
        check("rst_lead", int'(lead), 0);
        check("rst_errs", int'(err_runt) + int'(err_long), 0);
        check("rst_cnts", int'(cnt_ok) + int'(cnt_err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);

        // Nominal pulse
        n0 = n_strobe;
        pulse(8, t);
        idle(20);
        check("nom_count", n_strobe - n0, 1);
        check("nom_kind", last_kind, 4);
        check("nom_cycle", last_cyc - t, 11);
        check("nom_width", last_w, 8);
        check("nom_lead", last_l, 11);
        check("nom_busy_rise", busy_rise - t, 3);
        check("nom_busy_fall", busy_fall - t, 14);

        // Boundary widths
        for (int i = 0; i < 4; i++) begin
            n0 = n_strobe;
            pulse(bw[i], t);
            idle(20);
            check($sformatf("bnd%0d_count", bw[i]), n_strobe - n0, 1);
            check($sformatf("bnd%0d_kind", bw[i]), last_kind, bk[i]);
            check($sformatf("bnd%0d_width", bw[i]), last_w, bw[i]);
            check($sformatf("bnd%0d_cycle", bw[i]), last_cyc - t, bw[i] + 3);
        end

        // Stuck-high pulse saturates
        n0 = n_strobe;
        pulse(40, t);
        idle(20);
        check("long_count", n_strobe - n0, 1);
        check("long_kind", last_kind, 1);
        check("long_width", last_w, 10);
        check("long_lead", last_l, 13);
        check("long_cycle", last_cyc - t, 43);

        // Second pulse inside the hold-off is dropped
        n0 = n_strobe;
        pulse(8, t);
        @(posedge clk);
        pulse(8, t2);
        idle(20);
        check("gap_drop_count", n_strobe - n0, 1);
        check("gap_drop_cycle", last_cyc - t, 11);

        // Second pulse after the hold-off is accepted
        n0 = n_strobe;
        pulse(8, t);
        repeat (5) @(posedge clk);
        pulse(8, t2);
        idle(20);
        check("gap_ok_spacing", t2 - t, 14);
        check("gap_ok_count", n_strobe - n0, 2);
        check("gap_ok_cycle", last_cyc - t2, 11);

        // Reset in the middle of a pulse
        n0 = n_strobe;
        @(posedge clk);
        #1 pulse_in = 1'b1;
        t = cyc;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_width", int'(width), 0);
        check("rstmid_lead", int'(lead), 0);
        check("rstmid_strobe", int'(pulse_ok) + int'(err_runt) + int'(err_long), 0);
        @(posedge clk);
        @(posedge clk);
        #1 pulse_in = 1'b0;
        idle(20);
        check("rstmid_no_strobe", n_strobe - n0, 0);
        pulse(8, t);
        idle(20);
        check("rstmid_next_count", n_strobe - n0, 1);
        check("rstmid_next_kind", last_kind, 4);
        check("rstmid_next_width", last_w, 8);

`ifdef PULSE_STATS_EN
        @(posedge clk);
        #1 stats_clear = 1'b1;
        @(posedge clk);
        #1 stats_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(8, t);
            idle(14);
        end
        for (int i = 0; i < 2; i++) begin
            pulse(5, t);
            idle(14);
        end
        check("stats_ok", int'(cnt_ok), 3);
        check("stats_err", int'(cnt_err), 2);
        pulse(8, t);
        repeat (3) @(posedge clk);
        #1 stats_clear = 1'b1;
        @(negedge clk);
        check("stats_clr_strobe", int'(pulse_ok), 1);
        @(posedge clk);
        #1 stats_clear = 1'b0;
        @(negedge clk);
        check("stats_clr_ok", int'(cnt_ok), 0);
        check("stats_clr_err", int'(cnt_err), 0);
`else
        @(posedge clk);
        #1 stats_clear = 1'b1;
        pulse(8, t);
        idle(14);
        stats_clear = 1'b0;
        check("nostats_ok", int'(cnt_ok), 0);
        check("nostats_err", int'(cnt_err), 0);
`endif

        check("exclusive", excl_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
